led_seq_wb: RTL and testbench
=============================

# led_seq_wb

Wishbone master that drives the LED register slave autonomously. A programmable tick counter times each step; on every tick the block computes the next 7-bit LED pattern (walk, blink, count or host-supplied) and writes it to the slave with a single classic Wishbone write cycle. It sits between the system's status and configuration logic and the LED slave, so the host never has to bit-bang the LEDs. Bus faults and slow slaves are handled with a timeout, and status outputs report them.

## Interface
- DATA_WIDTH, 32, Wishbone data width (8/16/32/64).
- ADDR_WIDTH, 32, Wishbone address width.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- LED_ADDR, 0, address driven on every write.
- PERIOD_WIDTH, 24, width of i_period.
- TIMEOUT, 15, cycles to wait for ack/err before abandoning a cycle (≥1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- i_enable  in  1  run sequencer.
- i_mode  in  2  0 walk, 1 blink, 2 count, 3 hold.
- i_pattern  in  7  pattern used in hold mode.
- i_period  in  PERIOD_WIDTH  clocks per step; 0 is treated as 1.
- i_clear  in  1  one-cycle pulse; clears o_fault and o_overrun.
- wb_adr_o  out  ADDR_WIDTH  address.
- wb_dat_o  out  DATA_WIDTH  write data; upper bits zero above bit 6.
- wb_dat_i  in  DATA_WIDTH  read data; ignored.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  SELECT_WIDTH  byte selects.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.
- o_busy  out  1  bus cycle in progress.
- o_leds  out  7  last pattern acknowledged by the slave.
- o_fault  out  1  sticky; set on err or timeout.
- o_overrun  out  1  sticky; set when ticks were coalesced.

## Operation
- **Reset values.** All outputs are 0. Internal state is also cleared: tick counter = 0, pending = 0, state = IDLE, step = 0, last_mode = 0.
- **Tick counter.** Runs only while i_enable = 1 and counts 0..P-1, where P = max(i_period, 1).
  - A tick is raised in the cycle where count == P-1; the counter then wraps to 0.
  - With i_enable = 0, the counter is held at 0 and no ticks occur.
  - i_period is sampled continuously. If the count already exceeds P-1 after a change, the counter ticks and wraps on the next cycle.
- **Pending flag.** A tick sets pending. If a tick arrives while pending = 1 or while in WAIT, pending stays at 1 (ticks coalesce into one) and o_overrun is set.
- **FSM states.**
  - IDLE: if pending = 1 and i_enable = 1, latch i_mode and compute the next pattern N. Drive wb_adr_o = LED_ADDR, wb_dat_o = N zero-extended, wb_we_o = 1, wb_sel_o = all 1s, wb_cyc_o = wb_stb_o = 1. Clear pending (unless a new tick arrives in the same cycle) and go to WAIT.
  - WAIT: hold all bus outputs stable.
    - On wb_ack_i = 1: step ← N, o_leds ← N, drop cyc/stb/we, go to IDLE.
    - Else on wb_err_i = 1: set o_fault, drop the cycle, step unchanged, go to IDLE.
    - Else after TIMEOUT cycles in WAIT: same as err.
    - ack takes priority over err when both are high.
- **Pattern computation.** If the latched mode differs from last_mode, step is re-initialised before N is computed, and last_mode is updated.
  - walk: initial step 0x40; N = step rotated left by 1 within 7 bits (0x40 → 0x01).
  - blink: initial step 0x00; N = ~step within 7 bits (0x00 ↔ 0x7F).
  - count: initial step 0x00; N = step + 1 modulo 128 (0x7F → 0x00).
  - hold: N = i_pattern.
  - After reset, last_mode = 0 and step = 0. The initial-step rule for mode 0 (step = 0x40) still applies to the first write after reset.
- **Disable mid-cycle.** An active bus cycle always completes normally. After it, no new cycle starts, and pending and the counter clear while i_enable = 0.
- **i_clear.** Clears both sticky flags. If a set event occurs in the same cycle, set wins.
- **Reset mid-cycle.** cyc/stb drop immediately (asynchronous) and all state returns to reset values.

## Timing
- A tick at edge T sets pending. cyc/stb are high after edge T+1.
- With the registered LED slave (ack one cycle after stb), ack is sampled at edge T+3, cyc/stb are low after T+3, and o_leds updates at T+3.
- Minimum bus occupancy is 2 cycles. P ≥ 3 gives back-to-back steps without overrun against that slave.
- cyc/stb are never deasserted between issue and ack/err/timeout, and there is at least one idle cycle between consecutive bus cycles.
- Timeout: the cycle is abandoned at the TIMEOUT-th edge after entering WAIT without ack or err.

## Test plan
- **Walk.** Reset, then i_enable = 1, mode 0, period 4, slave acks after 1 cycle → writes 0x01, 0x02, 0x04, …, 0x40, 0x01 every 4 cycles; o_leds tracks each write; o_overrun stays 0.
- **Count and mode switch.** Mode 2, period 3, run 130 steps → wrap 0x7F → 0x00 observed. Then switch to mode 1 → next writes 0x7F, 0x00, 0x7F.
- **Overrun.** Period 0 (treated as 1) with a slave that acks after 4 cycles → o_overrun = 1, one write per bus cycle, no back-to-back cyc without an idle cycle. i_clear → o_overrun = 0.
- **Timeout.** Slave never acks, TIMEOUT = 15 → cyc drops after 15 WAIT cycles, o_fault = 1, o_leds unchanged. The next tick retries the same value.
- **Error.** wb_err_i asserted in hold mode with i_pattern = 0x55 → o_fault = 1, o_leds stays 0. Next tick with ack → o_leds = 0x55.
- **Reset mid-cycle.** Assert rst while in WAIT → cyc/stb = 0 immediately, all outputs 0. After release, the first write is 0x01 in mode 0.

Source files
------------

// File: rtl/led_seq_wb.sv
// Autonomous Wishbone master that steps a 7-bit LED pattern (walk/blink/count/hold)
// on a programmable tick and writes it to the LED slave, with err/timeout fault reporting.
//
// state  | meaning
// S_IDLE | no bus cycle; issue a write when a tick is pending and the sequencer is enabled
// S_WAIT | write cycle on the bus; waiting for ack, err or timeout
module led_seq_wb #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR     = '0,
    parameter int                    PERIOD_WIDTH = 24,
    parameter int                    TIMEOUT      = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic [1:0]              i_mode,
    input  logic [6:0]              i_pattern,
    input  logic [PERIOD_WIDTH-1:0] i_period,
    input  logic                    i_clear,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    o_busy,
    output logic [6:0]              o_leds,
    output logic                    o_fault,
    output logic                    o_overrun
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] count;
    logic [PERIOD_WIDTH-1:0] p_last;
    logic                    tick;
    logic                    pending;
    logic [TW-1:0]           tmr;
    logic                    tmr_last;
    logic                    done;
    logic [6:0]              step;
    logic [1:0]              last_mode;
    logic                    mode_valid;
    logic [6:0]              base;
    logic [6:0]              next_pat;
    logic [6:0]              n_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [SELECT_WIDTH-1:0] sel_q;
    logic                    cyc_q;
    logic                    we_q;
    logic [6:0]              leds_q;
    logic                    fault_q;
    logic                    overrun_q;
    logic                    unused_dat;

    assign unused_dat = ^wb_dat_i;

    assign p_last   = (i_period == '0) ? '0 : i_period - PERIOD_WIDTH'(1);
    // >= rather than == so a shrinking period wraps on the next cycle
    assign tick     = i_enable && (count >= p_last);
    assign tmr_last = (tmr == TW'(1));
    assign done     = (state == S_WAIT) && (wb_ack_i || wb_err_i || tmr_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!i_enable || tick) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_WIDTH'(1);
        end
    end

    // mode_valid forces the walk seed on the first write after reset even though last_mode is 0
    always_comb begin
        base = step;
        if (!mode_valid || (i_mode != last_mode)) begin
            base = (i_mode == 2'd0) ? 7'h40 : 7'h00;
        end
        case (i_mode)
            2'd0:    next_pat = {base[5:0], base[6]};
            2'd1:    next_pat = ~base;
            2'd2:    next_pat = base + 7'd1;
            default: next_pat = i_pattern;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            tmr        <= '0;
            step       <= '0;
            last_mode  <= '0;
            mode_valid <= 1'b0;
            n_q        <= '0;
            adr_q      <= '0;
            sel_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            leds_q     <= '0;
            fault_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (!i_enable) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end else if (state == S_IDLE) begin
                pending <= 1'b0;
            end

            // a tick landing on the completing edge is not an overrun
            if (tick && (pending || (state == S_WAIT && !done))) begin
                overrun_q <= 1'b1;
            end else if (i_clear) begin
                overrun_q <= 1'b0;
            end

            if (state == S_WAIT && !wb_ack_i && (wb_err_i || tmr_last)) begin
                fault_q <= 1'b1;
            end else if (i_clear) begin
                fault_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pending && i_enable) begin
                        last_mode  <= i_mode;
                        mode_valid <= 1'b1;
                        step       <= base;
                        n_q        <= next_pat;
                        adr_q      <= LED_ADDR;
                        sel_q      <= '1;
                        cyc_q      <= 1'b1;
                        we_q       <= 1'b1;
                        tmr        <= TW'(TIMEOUT);
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wb_ack_i) begin
                        step   <= n_q;
                        leds_q <= n_q;
                        cyc_q  <= 1'b0;
                        we_q   <= 1'b0;
                        state  <= S_IDLE;
                    end else if (wb_err_i || tmr_last) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = {{(DATA_WIDTH-7){1'b0}}, n_q};
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign o_busy    = cyc_q;
    assign o_leds    = leds_q;
    assign o_fault   = fault_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_led_seq_wb.sv
// Self-checking bench for led_seq_wb: programmable slave responder, bus monitor
// and a pattern reference model driven by randomized periods, latencies and patterns.
`timescale 1ns/1ps
module tb_led_seq_wb;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int PW = 24;
    localparam int TO = 15;
    localparam logic [AW-1:0] ADDR = 32'h0000_0040;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [1:0]    mode;
    logic [6:0]    pattern;
    logic [PW-1:0] period;
    logic          clear;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_we_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          o_busy;
    logic [6:0]    o_leds;
    logic          o_fault;
    logic          o_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_seq_wb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .LED_ADDR(ADDR),
        .PERIOD_WIDTH(PW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(enable), .i_mode(mode), .i_pattern(pattern),
        .i_period(period), .i_clear(clear), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .o_busy(o_busy),
        .o_leds(o_leds), .o_fault(o_fault), .o_overrun(o_overrun)
    );

    // slave: s_mode 0 = ack, 1 = err, 2 = silent; responds s_lat cycles after stb
    int   s_mode = 0;
    int   s_lat  = 1;
    int   s_cnt;
    logic ack_r, err_r;
    assign wb_ack_i = ack_r;
    assign wb_err_i = err_r;
    assign wb_dat_i = 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            s_cnt <= 0;
        end else if (wb_cyc_o && wb_stb_o && !ack_r && !err_r) begin
            if (s_cnt >= s_lat - 1) begin
                ack_r <= (s_mode == 0);
                err_r <= (s_mode == 1);
                s_cnt <= 0;
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            s_cnt <= 0;
        end
    end

    // bus monitor: logs cycle starts/ends; end kind 0 = ack, 1 = err, 2 = timeout
    int         cyc_n = 0;
    logic       prev_cyc;
    logic [7:0] prev_dat;
    int         resp;
    logic       exp_drop;
    int         stab_viol = 0;
    int         b2b_viol = 0;
    logic [7:0] st_dat[$];
    int         st_cyc[$];
    int         en_kind[$];
    int         en_cyc[$];
    int         proc_st = 0;
    int         proc_en = 0;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            prev_cyc <= 1'b0;
            prev_dat <= 8'h00;
            resp     <= 2;
            exp_drop <= 1'b0;
        end else begin
            cyc_n <= cyc_n + 1;
            if (wb_cyc_o && !prev_cyc) begin
                st_dat.push_back(wb_dat_o[7:0]);
                st_cyc.push_back(cyc_n);
                resp <= 2;
            end
            if (wb_cyc_o && wb_ack_i) resp <= 0;
            else if (wb_cyc_o && wb_err_i) resp <= 1;
            if (prev_cyc && !wb_cyc_o) begin
                en_kind.push_back(resp);
                en_cyc.push_back(cyc_n);
            end
            if ((wb_cyc_o && prev_cyc && wb_dat_o[7:0] != prev_dat) ||
                (wb_stb_o !== wb_cyc_o) || (wb_we_o !== wb_cyc_o) ||
                (wb_dat_o[DW-1:7] != '0))
                stab_viol <= stab_viol + 1;
            if (exp_drop && wb_cyc_o) b2b_viol <= b2b_viol + 1;
            exp_drop <= wb_cyc_o && (wb_ack_i || wb_err_i);
            prev_cyc <= wb_cyc_o;
            prev_dat <= wb_dat_o[7:0];
        end
    end

    // reference model of the pattern rules
    logic [6:0] m_step;
    int         m_last;
    bit         m_valid;

    task automatic model_issue(input int md, input logic [6:0] pat, output logic [6:0] n);
        int s;
        if (!m_valid || md != m_last) begin
            m_step  = (md == 0) ? 7'h40 : 7'h00;
            m_last  = md;
            m_valid = 1'b1;
        end
        s = int'(m_step);
        case (md)
            0:       n = 7'((s * 2) % 128 + s / 64);
            1:       n = 7'(127 - s);
            2:       n = 7'((s + 1) % 128);
            default: n = pat;
        endcase
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    // returns 8'hFF / -1 when the budget expires so the caller's compare fails
    task automatic next_start(output logic [7:0] d, output int c);
        int n = 0;
        while (st_dat.size() <= proc_st && n < 400) begin nstep(); n++; end
        if (st_dat.size() > proc_st) begin
            d = st_dat[proc_st];
            c = st_cyc[proc_st];
            proc_st++;
        end else begin
            d = 8'hFF;
            c = -1;
        end
    endtask

    task automatic next_end(output int kind, output int c);
        int n = 0;
        while (en_kind.size() <= proc_en && n < 400) begin nstep(); n++; end
        if (en_kind.size() > proc_en) begin
            kind = en_kind[proc_en];
            c    = en_cyc[proc_en];
            proc_en++;
        end else begin
            kind = -1;
            c    = -1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        repeat (3) nstep();
        st_dat.delete(); st_cyc.delete(); en_kind.delete(); en_cyc.delete();
        proc_st = 0; proc_en = 0;
        m_valid = 1'b0; m_step = 7'h00; m_last = 0;
        rst = 1'b1;
        nstep();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, o_busy, o_fault, o_overrun} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000000",
                     {wb_cyc_o, wb_stb_o, wb_we_o, o_busy, o_fault, o_overrun});
        end
        checks++;
        if (o_leds !== 7'h00) begin errors++; $display("FAIL reset_leds got %h expected 00", o_leds); end
        checks++;
        if (wb_dat_o !== '0 || wb_adr_o !== '0 || wb_sel_o !== '0) begin
            errors++;
            $display("FAIL reset_bus got dat %h adr %h sel %h expected zeros", wb_dat_o, wb_adr_o, wb_sel_o);
        end
    endtask

    task automatic test_walk();
        logic [7:0] d;
        logic [6:0] e;
        int c, pc, k, kc, p;
        do_reset();
        p = $urandom_range(7, 4);
        s_mode = 0; s_lat = 1; mode = 2'd0; period = PW'(p); enable = 1'b1;
        pc = 0;
        for (int i = 0; i < 9; i++) begin
            next_start(d, c);
            model_issue(0, pattern, e);
            checks++;
            if (d !== {1'b0, e}) begin errors++; $display("FAIL walk_dat[%0d] got %h expected %h", i, d, e); end
            if (i == 0) begin
                checks++;
                if (d !== 8'h01) begin errors++; $display("FAIL walk_first got %h expected 01", d); end
                checks++;
                if (wb_adr_o !== ADDR || wb_sel_o !== 4'hF || wb_we_o !== 1'b1) begin
                    errors++;
                    $display("FAIL walk_ctrl got adr %h sel %h we %b expected %h f 1", wb_adr_o, wb_sel_o, wb_we_o, ADDR);
                end
            end else begin
                checks++;
                if (c - pc !== p) begin errors++; $display("FAIL walk_interval got %0d expected %0d", c - pc, p); end
            end
            pc = c;
            next_end(k, kc);
            checks++;
            if (k !== 0) begin errors++; $display("FAIL walk_kind got %0d expected 0", k); end
            else m_step = e;
            checks++;
            if (o_leds !== e) begin errors++; $display("FAIL walk_leds got %h expected %h", o_leds, e); end
        end
        checks++;
        if (o_overrun !== 1'b0) begin errors++; $display("FAIL walk_overrun got %b expected 0", o_overrun); end
    endtask

    task automatic test_count_switch();
        logic [7:0] d, pd;
        logic [6:0] e;
        logic [6:0] blink_exp [3];
        int c, k, kc;
        bit wrap_seen;
        do_reset();
        blink_exp[0] = 7'h7F; blink_exp[1] = 7'h00; blink_exp[2] = 7'h7F;
        s_mode = 0; s_lat = 1; mode = 2'd2; period = PW'(3); enable = 1'b1;
        wrap_seen = 1'b0; pd = 8'h00;
        for (int i = 0; i < 130; i++) begin
            next_start(d, c);
            model_issue(2, pattern, e);
            checks++;
            if (d !== {1'b0, e}) begin errors++; $display("FAIL count_dat[%0d] got %h expected %h", i, d, e); end
            if (pd == 8'h7F && d == 8'h00) wrap_seen = 1'b1;
            pd = d;
            next_end(k, kc);
            checks++;
            if (k !== 0) begin errors++; $display("FAIL count_kind got %0d expected 0", k); end
            else m_step = e;
        end
        mode = 2'd1;
        checks++;
        if (wrap_seen !== 1'b1) begin errors++; $display("FAIL count_wrap got %b expected 1", wrap_seen); end
        checks++;
        if (o_overrun !== 1'b0) begin errors++; $display("FAIL count_overrun got %b expected 0", o_overrun); end
        for (int i = 0; i < 3; i++) begin
            next_start(d, c);
            model_issue(1, pattern, e);
            checks++;
            if (d !== {1'b0, blink_exp[i]}) begin
                errors++; $display("FAIL blink_dat[%0d] got %h expected %h", i, d, blink_exp[i]);
            end
            next_end(k, kc);
            if (k == 0) m_step = e;
            checks++;
            if (o_leds !== blink_exp[i]) begin
                errors++; $display("FAIL blink_leds[%0d] got %h expected %h", i, o_leds, blink_exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic [6:0] e;
        int c, pc, k, kc;
        do_reset();
        s_mode = 0; s_lat = 4; mode = 2'd2; period = '0; enable = 1'b1;
        pc = 0;
        for (int i = 0; i < 7; i++) begin
            next_start(d, c);
            model_issue(2, pattern, e);
            checks++;
            if (d !== {1'b0, e}) begin errors++; $display("FAIL ovr_dat[%0d] got %h expected %h", i, d, e); end
            if (i > 0) begin
                checks++;
                if (c - pc !== 6) begin errors++; $display("FAIL ovr_interval got %0d expected 6", c - pc); end
            end
            pc = c;
            if (i == 6) enable = 1'b0;
            next_end(k, kc);
            checks++;
            if (k !== 0) begin errors++; $display("FAIL ovr_kind got %0d expected 0", k); end
            else m_step = e;
            checks++;
            if (o_leds !== e) begin errors++; $display("FAIL ovr_leds got %h expected %h", o_leds, e); end
        end
        checks++;
        if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b expected 1", o_overrun); end
        repeat (20) nstep();
        checks++;
        if (st_dat.size() !== proc_st) begin
            errors++; $display("FAIL ovr_disabled_starts got %0d expected %0d", st_dat.size(), proc_st);
        end
        clear = 1'b1; nstep(); clear = 1'b0; nstep();
        checks++;
        if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b expected 0", o_overrun); end
        checks++;
        if (b2b_viol !== 0 || stab_viol !== 0) begin
            errors++; $display("FAIL bus_rules got b2b %0d stab %0d expected 0 0", b2b_viol, stab_viol);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d, d2;
        logic [6:0] e;
        int c, k, kc;
        do_reset();
        s_mode = 0; s_lat = 1; mode = 2'd2; period = PW'(40); enable = 1'b1;
        next_start(d, c);
        model_issue(2, pattern, e);
        next_end(k, kc);
        if (k == 0) m_step = e;
        checks++;
        if (o_leds !== 7'h01) begin errors++; $display("FAIL to_first_leds got %h expected 01", o_leds); end
        s_mode = 2;
        next_start(d2, c);
        model_issue(2, pattern, e);
        checks++;
        if (d2 !== {1'b0, e}) begin errors++; $display("FAIL to_dat got %h expected %h", d2, e); end
        next_end(k, kc);
        checks++;
        if (k !== 2) begin errors++; $display("FAIL to_kind got %0d expected 2", k); end
        checks++;
        if (kc - c !== TO) begin errors++; $display("FAIL to_length got %0d expected %0d", kc - c, TO); end
        checks++;
        if (o_fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b expected 1", o_fault); end
        checks++;
        if (o_leds !== 7'h01) begin errors++; $display("FAIL to_leds got %h expected 01", o_leds); end
        s_mode = 0;
        next_start(d, c);
        model_issue(2, pattern, e);
        checks++;
        if (d !== d2 || d !== {1'b0, e}) begin errors++; $display("FAIL to_retry got %h expected %h", d, d2); end
        next_end(k, kc);
        if (k == 0) m_step = e;
        checks++;
        if (o_leds !== e) begin errors++; $display("FAIL to_retry_leds got %h expected %h", o_leds, e); end
        enable = 1'b0;
        clear = 1'b1; nstep(); clear = 1'b0; nstep();
        checks++;
        if (o_fault !== 1'b0) begin errors++; $display("FAIL to_clear got %b expected 0", o_fault); end
    endtask

    task automatic test_error();
        logic [7:0] d;
        int c, k, kc;
        do_reset();
        s_mode = 1; s_lat = 1; mode = 2'd3; pattern = 7'h55; period = PW'(6); enable = 1'b1;
        next_start(d, c);
        checks++;
        if (d !== 8'h55) begin errors++; $display("FAIL err_dat got %h expected 55", d); end
        next_end(k, kc);
        s_mode = 0;
        checks++;
        if (k !== 1) begin errors++; $display("FAIL err_kind got %0d expected 1", k); end
        checks++;
        if (o_fault !== 1'b1 || o_leds !== 7'h00) begin
            errors++; $display("FAIL err_state got fault %b leds %h expected 1 00", o_fault, o_leds);
        end
        next_start(d, c);
        next_end(k, kc);
        checks++;
        if (k !== 0 || o_leds !== 7'h55) begin
            errors++; $display("FAIL err_retry got kind %0d leds %h expected 0 55", k, o_leds);
        end
        checks++;
        if (o_fault !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", o_fault); end
    endtask

    task automatic test_hold_random();
        logic [7:0] d;
        logic [6:0] e;
        int c, k, kc;
        do_reset();
        s_mode = 0; s_lat = 1; mode = 2'd3; period = PW'($urandom_range(10, 6));
        pattern = 7'($urandom); enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_start(d, c);
            model_issue(3, pattern, e);
            checks++;
            if (d !== {1'b0, e}) begin errors++; $display("FAIL hold_dat[%0d] got %h expected %h", i, d, e); end
            next_end(k, kc);
            if (k == 0) m_step = e;
            checks++;
            if (o_leds !== e) begin errors++; $display("FAIL hold_leds[%0d] got %h expected %h", i, o_leds, e); end
            pattern = 7'($urandom);
            s_lat = $urandom_range(3, 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int c, k, kc;
        do_reset();
        s_mode = 0; s_lat = 1; mode = 2'd0; period = PW'(5); enable = 1'b1;
        next_start(d, c);
        next_end(k, kc);
        s_mode = 2;
        next_start(d, c);
        repeat (3) nstep();
        rst = 1'b0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, o_busy} !== 4'b0) begin
            errors++; $display("FAIL mid_rst_bus got %b expected 0000", {wb_cyc_o, wb_stb_o, wb_we_o, o_busy});
        end
        checks++;
        if (o_leds !== 7'h00 || wb_dat_o !== '0 || o_fault !== 1'b0 || o_overrun !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out got leds %h dat %h expected 00 0", o_leds, wb_dat_o);
        end
        s_mode = 0;
        do_reset();
        enable = 1'b1;
        next_start(d, c);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL mid_rst_first got %h expected 01", d); end
        next_end(k, kc);
        checks++;
        if (o_leds !== 7'h01) begin errors++; $display("FAIL mid_rst_leds got %h expected 01", o_leds); end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; mode = 2'd0; pattern = 7'h00; period = PW'(4); clear = 1'b0;
        test_reset();
        test_walk();
        test_count_switch();
        test_overrun();
        test_timeout();
        test_error();
        test_hold_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
